// File: rtl/seq_gen_pkg.sv
// Shared constants for the programmable sequence generator: mode encoding
// (also the FSM state, exported directly on the mode port) and rate code width.
package seq_gen_pkg;

  localparam int PROG_W = 3;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_FIB   = 2'd1,
    MODE_TIMER = 2'd2,
    MODE_DOWN  = 2'd3
  } mode_t;

endpackage

// File: rtl/rate_prescaler.sv
// Rate prescaler: emits tick_en once every (BASE_DIV << prog_r) clocks.
// clear restarts the period so the next tick_en comes a full period later;
// tick_en is suppressed in the clearing cycle.
module rate_prescaler
  import seq_gen_pkg::*;
#(
  parameter int BASE_DIV = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic [PROG_W-1:0] prog_r,
  output logic              tick_en
);

  localparam int MAX_SHIFT = (1 << PROG_W) - 1;
  localparam int CNT_W     = $clog2(BASE_DIV * (1 << MAX_SHIFT) + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period;
  logic             last;

  assign period  = CNT_W'(BASE_DIV) << prog_r;
  assign last    = (cnt == period - CNT_W'(1));
  assign tick_en = last && !clear;

  // Period counter: wraps at period-1, restarts on clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_gen_prog.sv
// Programmable sequence generator: Fibonacci, up-timer and load-and-countdown
// at a rate set by a sticky rate register. Build option DOWN_MODE_EN enables
// the countdown mode; without it start_d/load_val are ignored.
// Handshake: all command inputs are single-cycle pulses sampled on the rising
// clock edge; there is no back-pressure. Priority: stop > start_f > start_t >
// start_d; update is independent and may coincide with any command.
module seq_gen_prog
  import seq_gen_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int BASE_DIV = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_f,
  input  logic              start_t,
  input  logic              start_d,
  input  logic              stop_f_t,
  input  logic              update,
  input  logic [PROG_W-1:0] prog,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  value,
  output logic [1:0]        mode,
  output logic              tick,
  output logic              done,
  output logic              ovf,
  output logic              parity
);

  mode_t             state_q, state_d;
  logic [WIDTH-1:0]  value_d;
  logic [WIDTH:0]    nxt_q, nxt_d;
  logic              ovf_d, tick_d, done_d;
  logic [PROG_W-1:0] prog_q;
  logic              go_down;
  logic              clear;
  logic              tick_en;

`ifdef DOWN_MODE_EN
  assign go_down = start_d;
`else
  logic unused_down;
  assign go_down     = 1'b0;
  assign unused_down = ^{start_d, load_val};
`endif

  assign clear  = start_f | start_t | go_down | update;
  assign mode   = state_q;
  assign parity = ^value;

  rate_prescaler #(.BASE_DIV(BASE_DIV)) u_prescaler (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear),
    .prog_r  (prog_q),
    .tick_en (tick_en)
  );

  // Next-state and datapath: commands first, then per-mode advance on tick_en.
  always_comb begin
    state_d = state_q;
    value_d = value;
    nxt_d   = nxt_q;
    ovf_d   = ovf;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    if (stop_f_t) begin
      state_d = MODE_IDLE;
    end else if (start_f) begin
      state_d = MODE_FIB;
      value_d = '0;
      nxt_d   = (WIDTH+1)'(1);
      ovf_d   = 1'b0;
    end else if (start_t) begin
      state_d = MODE_TIMER;
      value_d = '0;
      ovf_d   = 1'b0;
`ifdef DOWN_MODE_EN
    end else if (start_d) begin
      state_d = MODE_DOWN;
      value_d = load_val;
      ovf_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        MODE_FIB: begin
          if (tick_en) begin
            if (nxt_q[WIDTH]) begin
              // Next term no longer fits: stop on the last valid term.
              ovf_d   = 1'b1;
              done_d  = 1'b1;
              state_d = MODE_IDLE;
            end else begin
              value_d = nxt_q[WIDTH-1:0];
              nxt_d   = {1'b0, value} + nxt_q;
              tick_d  = 1'b1;
            end
          end
        end
        MODE_TIMER: begin
          if (tick_en) begin
            value_d = value + WIDTH'(1);
            tick_d  = 1'b1;
            if (&value) ovf_d = 1'b1;
          end
        end
`ifdef DOWN_MODE_EN
        MODE_DOWN: begin
          if (value == '0) begin
            // Loaded with zero: finish at once without advancing.
            done_d  = 1'b1;
            state_d = MODE_IDLE;
          end else if (tick_en) begin
            value_d = value - WIDTH'(1);
            tick_d  = 1'b1;
            if (value == WIDTH'(1)) begin
              done_d  = 1'b1;
              state_d = MODE_IDLE;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // State, datapath and status registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= MODE_IDLE;
      value   <= '0;
      nxt_q   <= '0;
      ovf     <= 1'b0;
      tick    <= 1'b0;
      done    <= 1'b0;
      prog_q  <= '0;
    end else begin
      state_q <= state_d;
      value   <= value_d;
      nxt_q   <= nxt_d;
      ovf     <= ovf_d;
      tick    <= tick_d;
      done    <= done_d;
      if (update) prog_q <= prog;
    end
  end

endmodule

// File: tb/tb_seq_gen_prog.sv
// Directed testbench for seq_gen_prog (WIDTH=8, BASE_DIV=4).
module tb_seq_gen_prog;

  localparam int WIDTH = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             start_f, start_t, start_d, stop_f_t, update;
  logic [2:0]       prog;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] value;
  logic [1:0]       mode;
  logic             tick, done, ovf, parity;

  int n_tests = 0;
  int n_fail  = 0;
  int n;

  seq_gen_prog #(.WIDTH(WIDTH), .BASE_DIV(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .start_f  (start_f),
    .start_t  (start_t),
    .start_d  (start_d),
    .stop_f_t (stop_f_t),
    .update   (update),
    .prog     (prog),
    .load_val (load_val),
    .value    (value),
    .mode     (mode),
    .tick     (tick),
    .done     (done),
    .ovf      (ovf),
    .parity   (parity)
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver helpers: inputs change and outputs are sampled 1 time unit after posedge.
  task automatic clk1();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Clocks until tick (or done) is seen, bounded by budget.
  task automatic wait_for(input bit on_done, input int budget, output int cnt);
    cnt = 0;
    do begin
      clk1();
      cnt++;
    end while (((on_done ? done : tick) !== 1'b1) && cnt < budget);
  endtask

  task automatic do_update(input logic [2:0] p);
    update = 1'b1; prog = p;
    clk1();
    update = 1'b0;
  endtask

  logic [7:0] fib_exp [6] = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8};
  logic       par_exp [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    reset = 1'b1;
    start_f = 0; start_t = 0; start_d = 0; stop_f_t = 0; update = 0;
    prog = '0; load_val = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_value", value, 0);
    check("rst_mode", mode, 0);
    check("rst_tick", tick, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_parity", parity, 0);

    // Rate 3 (period 32) and Fibonacci
    do_update(3'd3);
    start_f = 1'b1; clk1(); start_f = 1'b0;
    check("fib_load_value", value, 0);
    check("fib_load_mode", mode, 1);
    for (int i = 0; i < 6; i++) begin
      wait_for(1'b0, 100, n);
      check("fib_period", n, 32);
      check("fib_value", value, fib_exp[i]);
      check("fib_parity", parity, par_exp[i]);
    end

    // Fibonacci overflow at rate 0
    do_update(3'd0);
    start_f = 1'b1; clk1(); start_f = 1'b0;
    for (int i = 0; i < 13; i++) wait_for(1'b0, 20, n);
    check("fibovf_last_value", value, 233);
    check("fibovf_ovf_before", ovf, 0);
    wait_for(1'b1, 20, n);
    check("fibovf_done_delay", n, 4);
    check("fibovf_value_held", value, 233);
    check("fibovf_ovf", ovf, 1);
    check("fibovf_mode", mode, 0);
    check("fibovf_no_tick", tick, 0);
    clk1();
    check("fibovf_done_single", done, 0);

    // Timer wrap
    start_t = 1'b1; clk1(); start_t = 1'b0;
    check("tmr_load_value", value, 0);
    check("tmr_ovf_cleared", ovf, 0);
    check("tmr_mode", mode, 2);
    for (int i = 0; i < 255; i++) wait_for(1'b0, 20, n);
    check("tmr_value_255", value, 255);
    check("tmr_ovf_pre_wrap", ovf, 0);
    wait_for(1'b0, 20, n);
    check("tmr_wrap_period", n, 4);
    check("tmr_wrap_value", value, 0);
    check("tmr_wrap_ovf", ovf, 1);
    wait_for(1'b0, 20, n);
    check("tmr_continue_value", value, 1);
    check("tmr_continue_mode", mode, 2);
    start_t = 1'b1; clk1(); start_t = 1'b0;
    check("tmr_restart_ovf", ovf, 0);
    check("tmr_restart_value", value, 0);

    // Stop wins over a simultaneous start
    for (int i = 0; i < 3; i++) wait_for(1'b0, 20, n);
    check("stop_pre_value", value, 3);
    stop_f_t = 1'b1; start_t = 1'b1; clk1(); stop_f_t = 1'b0; start_t = 1'b0;
    check("stop_mode", mode, 0);
    check("stop_value", value, 3);
    repeat (10) clk1();
    check("stop_value_held", value, 3);
    check("stop_mode_held", mode, 0);

    // Rate change mid-timer
    start_t = 1'b1; clk1(); start_t = 1'b0;
    wait_for(1'b0, 20, n);
    check("upd_first_period", n, 4);
    repeat (2) clk1();
    do_update(3'd1);
    wait_for(1'b0, 40, n);
    check("upd_new_period", n, 8);
    check("upd_value", value, 2);

`ifdef DOWN_MODE_EN
    // Countdown from 3 at period 4
    do_update(3'd0);
    load_val = 8'd3; start_d = 1'b1; clk1(); start_d = 1'b0;
    check("down_load_value", value, 3);
    check("down_load_mode", mode, 3);
    wait_for(1'b0, 20, n);
    check("down_value_2", value, 2);
    check("down_done_early", done, 0);
    wait_for(1'b0, 20, n);
    check("down_value_1", value, 1);
    wait_for(1'b0, 20, n);
    check("down_value_0", value, 0);
    check("down_done", done, 1);
    check("down_idle", mode, 0);

    // Countdown from 0
    load_val = 8'd0; start_d = 1'b1; clk1(); start_d = 1'b0;
    check("down0_mode", mode, 3);
    check("down0_done_early", done, 0);
    clk1();
    check("down0_done", done, 1);
    check("down0_no_tick", tick, 0);
    check("down0_idle", mode, 0);
`else
    // start_d ignored without countdown support
    stop_f_t = 1'b1; clk1(); stop_f_t = 1'b0;
    load_val = 8'd3; start_d = 1'b1; clk1(); start_d = 1'b0;
    check("nodown_mode", mode, 0);
    check("nodown_value", value, 2);
    repeat (10) clk1();
    check("nodown_done", done, 0);
`endif

    // Asynchronous reset mid-operation, then rate register back to 0
    do_update(3'd2);
`ifdef DOWN_MODE_EN
    load_val = 8'd200; start_d = 1'b1; clk1(); start_d = 1'b0;
    wait_for(1'b0, 40, n);
    wait_for(1'b0, 40, n);
    check("areset_pre_value", value, 198);
`else
    start_t = 1'b1; clk1(); start_t = 1'b0;
    wait_for(1'b0, 40, n);
    wait_for(1'b0, 40, n);
    check("areset_pre_value", value, 2);
`endif
    #3;
    reset = 1'b1;
    #1;
    check("areset_value", value, 0);
    check("areset_mode", mode, 0);
    check("areset_tick", tick, 0);
    check("areset_done", done, 0);
    check("areset_ovf", ovf, 0);
    check("areset_parity", parity, 0);
    clk1();
    reset = 1'b0;
    start_t = 1'b1; clk1(); start_t = 1'b0;
    wait_for(1'b0, 40, n);
    check("areset_prog_period", n, 4);
    check("areset_timer_value", value, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
